i_fetch: RTL and testbench

//  Instruction-fetch stage of the 5-stage MIPS pipeline; sits directly upstream of i_decode.

---
 rtl/i_fetch_pkg.sv | 23 ++
 rtl/i_fetch_if.sv | 14 +
 rtl/i_fetch_if_id.sv | 39 +++
 rtl/i_fetch.sv | 121 ++++++++++++
 tb/tb_i_fetch.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/i_fetch_pkg.sv
// Shared types and default constants for the instruction-fetch stage.
// Holds the fetch FSM state encoding and the IF/ID register payload.
package i_fetch_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RESET_PC_DEF  = 32'h0000_0000;
  localparam word_t NOP_INSTR_DEF = 32'h0000_0000;
  localparam word_t PC_STEP_DEF   = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    word_t instr;
    word_t npc;
    logic  valid;
  } if_id_t;

endpackage

// File: rtl/i_fetch_if.sv
// Instruction-memory req/ack read port.
// The fetch stage is the master; the memory (or its model) is the slave.
interface i_fetch_if;
  import i_fetch_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ack;
  word_t imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/i_fetch_if_id.sv
// IF/ID pipeline register: flush writes a bubble, load captures a new entry,
// otherwise the entry is held. Flush wins over load.
module i_fetch_if_id
  import i_fetch_pkg::*;
#(
  parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t entry_q, entry_d;

  // NOTE: entry_d gets its default before any branch so no latch is inferred.
  always_comb begin
    entry_d = entry_q;
    if (flush) begin
      entry_d = '{instr: NOP_INSTR, npc: '0, valid: 1'b0};
    end else if (load) begin
      entry_d = d;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '{instr: NOP_INSTR, npc: '0, valid: 1'b0};
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q = entry_q;

endmodule

// File: rtl/i_fetch.sv
// Instruction-fetch stage: owns the PC, issues req/ack reads to instruction
// memory, applies branch redirects and feeds the IF/ID register.
module i_fetch
  import i_fetch_pkg::*;
#(
  parameter word_t RESET_PC  = RESET_PC_DEF,
  parameter word_t NOP_INSTR = NOP_INSTR_DEF,
  parameter word_t PC_STEP   = PC_STEP_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  EX_MEM_pc_src,
  input  word_t EX_MEM_branch_target,
  input  logic  stall,
  input  logic  flush,
  i_fetch_if.master imem,
  output word_t IF_ID_instruction_out,
  output word_t IF_ID_npc_out,
  output logic  IF_ID_valid
);

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        tgt_q, tgt_d;
  word_t        hold_q, hold_d;
  logic         pend_q, pend_d;

  word_t        pc_next;
  logic         discard;
  logic         ifid_load;
  logic         ifid_flush;
  if_id_t       ifid_in;
  if_id_t       ifid_out;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    hold_d    = hold_q;
    pend_d    = pend_q;
    discard   = 1'b0;
    ifid_load = 1'b0;
    pc_next   = pc_q + PC_STEP;
    ifid_in   = '{instr: hold_q, npc: pc_next, valid: 1'b1};

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (EX_MEM_pc_src) pc_d = EX_MEM_branch_target;
      end
      ST_FETCH: begin
        if (imem.imem_ack) begin
          if (EX_MEM_pc_src || pend_q) begin
            // A same-cycle redirect is newer than any parked target.
            discard = 1'b1;
            pend_d  = 1'b0;
            pc_d    = EX_MEM_pc_src ? EX_MEM_branch_target : tgt_q;
          end else if (!stall) begin
            ifid_load     = 1'b1;
            ifid_in.instr = imem.imem_rdata;
            pc_d          = pc_next;
          end else begin
            hold_d  = imem.imem_rdata;
            state_d = ST_HOLD;
          end
        end else if (EX_MEM_pc_src) begin
          // Address must stay put while req is outstanding; park the target.
          pend_d = 1'b1;
          tgt_d  = EX_MEM_branch_target;
        end
      end
      ST_HOLD: begin
        if (EX_MEM_pc_src) begin
          discard = 1'b1;
          pc_d    = EX_MEM_branch_target;
          state_d = ST_FETCH;
        end else if (!stall) begin
          ifid_load = 1'b1;
          pc_d      = pc_next;
          state_d   = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ifid_flush = flush || (discard && !stall);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      hold_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
    end
  end

  assign imem.imem_req  = (state_q == ST_FETCH);
  assign imem.imem_addr = pc_q;

  i_fetch_if_id #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ifid_load),
    .flush (ifid_flush),
    .d     (ifid_in),
    .q     (ifid_out)
  );

  assign IF_ID_instruction_out = ifid_out.instr;
  assign IF_ID_npc_out         = ifid_out.npc;
  assign IF_ID_valid           = ifid_out.valid;

endmodule

// File: tb/tb_i_fetch.sv
// Bench for i_fetch: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level model of the fetch stage.
module tb_i_fetch;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic        pc_src, stall, flush;
  logic [31:0] target;
  logic [31:0] instr, npc, instr2, npc2;
  logic        valid, valid2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  i_fetch_if bus ();
  i_fetch_if bus2 ();

  i_fetch dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .EX_MEM_pc_src         (pc_src),
    .EX_MEM_branch_target  (target),
    .stall                 (stall),
    .flush                 (flush),
    .imem                  (bus),
    .IF_ID_instruction_out (instr),
    .IF_ID_npc_out         (npc),
    .IF_ID_valid           (valid)
  );

  i_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk                   (clk),
    .rst_n                 (rst2_n),
    .EX_MEM_pc_src         (1'b0),
    .EX_MEM_branch_target  (32'h0),
    .stall                 (1'b0),
    .flush                 (1'b0),
    .imem                  (bus2),
    .IF_ID_instruction_out (instr2),
    .IF_ID_npc_out         (npc2),
    .IF_ID_valid           (valid2)
  );

  // Zero-wait memory for the wrap-around instance.
  assign bus2.imem_ack   = bus2.imem_req;
  assign bus2.imem_rdata = bus2.imem_addr ^ 32'hA5A5_0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_started, m_held, m_pend, m_valid;
  logic [31:0] m_pc, m_tgt, m_hword, m_instr, m_npc;

  function automatic void model_reset();
    m_started = 0; m_held = 0; m_pend = 0;
    m_pc = 32'h0; m_tgt = 32'h0; m_hword = 32'h0;
    m_instr = 32'h0; m_npc = 32'h0; m_valid = 0;
  endfunction

  function automatic void model_step();
    bit          discard = 0;
    bit          load = 0;
    logic [31:0] word = 32'h0;
    if (!m_started) begin
      m_started = 1;
      if (pc_src) m_pc = target;
    end else if (m_held) begin
      if (pc_src) begin
        m_pc = target; m_held = 0; discard = 1;
      end else if (!stall) begin
        load = 1; word = m_hword; m_held = 0;
      end
    end else if (bus.imem_ack) begin
      if (pc_src || m_pend) begin
        m_pc = pc_src ? target : m_tgt; m_pend = 0; discard = 1;
      end else if (!stall) begin
        load = 1; word = bus.imem_rdata;
      end else begin
        m_held = 1; m_hword = bus.imem_rdata;
      end
    end else if (pc_src) begin
      m_pend = 1; m_tgt = target;
    end
    if (flush || (discard && !stall)) begin
      m_instr = 32'h0; m_npc = 32'h0; m_valid = 0;
    end else if (load) begin
      m_instr = word; m_npc = m_pc + 32'd4; m_valid = 1;
    end
    if (load) m_pc = m_pc + 32'd4;
  endfunction

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("req",   32'(bus.imem_req), 32'(m_started && !m_held));
      check("addr",  bus.imem_addr, m_pc);
      check("instr", instr, m_instr);
      check("npc",   npc, m_npc);
      check("valid", 32'(valid), 32'(m_valid));
    end
  end

  // ---------------- memory slave ----------------
  int lat = 0;
  int wait_cnt = 0;
  bit rand_lat = 0;
  bit junk_en = 0;

  task automatic mem_drive();
    if (bus.imem_req) begin
      if (wait_cnt >= lat) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;
        wait_cnt = 0;
        if (rand_lat) lat = int'($urandom_range(0, 3));
      end else begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        wait_cnt++;
      end
    end else begin
      bus.imem_ack   = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.imem_rdata = $urandom;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    #1;
    mem_drive();
  endtask

  task automatic do_reset(input int l);
    rst_n = 1'b0;
    pc_src = 1'b0; stall = 1'b0; flush = 1'b0; target = 32'h0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
    lat = l; wait_cnt = 0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_tests %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst2_n = 1'b0;
    do_reset(0);
    cmp_en = 1;
    check("rst_req",   32'(bus.imem_req), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);

    // 1: zero-wait streaming
    tick();
    check("t1_req_c1", 32'(bus.imem_req), 32'h1);
    tick(); check("t1_npc4", npc, 32'h4); check("t1_instr0", instr, 32'hA5A5_0000);
    tick(); check("t1_npc8", npc, 32'h8);
    tick(); check("t1_npc12", npc, 32'hC); check("t1_instr8", instr, 32'hA5A5_0008);

    // 2: two-cycle ack latency
    do_reset(2);
    tick(); check("t2_addr_a", bus.imem_addr, 32'h0);
    tick(); check("t2_addr_b", bus.imem_addr, 32'h0);
    tick(); check("t2_addr_c", bus.imem_addr, 32'h0); check("t2_valid0", 32'(valid), 32'h0);
    tick(); check("t2_npc4", npc, 32'h4); check("t2_addr4", bus.imem_addr, 32'h4);
    tick(); tick(); check("t2_npc_hold", npc, 32'h4);
    tick(); check("t2_npc8", npc, 32'h8);

    // 3: stall coinciding with the ack at pc 0x8
    do_reset(0);
    tick(); tick(); tick();
    check("t3_addr8", bus.imem_addr, 32'h8);
    stall = 1'b1;
    tick(); check("t3_req0", 32'(bus.imem_req), 32'h0); check("t3_frozen", npc, 32'h8);
    tick(); tick(); check("t3_frozen2", npc, 32'h8);
    stall = 1'b0;
    tick();
    check("t3_npcC", npc, 32'hC); check("t3_instr8", instr, 32'hA5A5_0008);
    check("t3_addrC", bus.imem_addr, 32'hC);

    // 4: redirect while the 0x10 fetch is pending
    do_reset(2);
    for (int i = 0; i < 40 && bus.imem_addr != 32'h10; i++) tick();
    check("t4_at_0x10", bus.imem_addr, 32'h10);
    pc_src = 1'b1; target = 32'h100;
    tick();
    pc_src = 1'b0;
    check("t4_addr_held", bus.imem_addr, 32'h10);
    for (int i = 0; i < 10 && valid; i++) tick();
    check("t4_dropped", 32'(valid), 32'h0);
    check("t4_nop", instr, 32'h0);
    check("t4_addr100", bus.imem_addr, 32'h100);
    for (int i = 0; i < 10 && !valid; i++) tick();
    check("t4_npc104", npc, 32'h104);

    // 5: flush together with stall
    do_reset(0);
    tick(); tick(); tick();
    stall = 1'b1; flush = 1'b1;
    tick();
    check("t5_valid0", 32'(valid), 32'h0); check("t5_nop", instr, 32'h0);
    check("t5_npc0", npc, 32'h0); check("t5_pc8", bus.imem_addr, 32'h8);
    stall = 1'b0; flush = 1'b0;
    tick(); check("t5_resume", npc, 32'hC);

    // 6: wrap-around reset PC and asynchronous reset mid-request
    rst2_n = 1'b1;
    tick(); check("t6_addr_top", bus2.imem_addr, 32'hFFFF_FFFC);
    tick(); check("t6_npc0", npc2, 32'h0); check("t6_instr", instr2, 32'h5A5A_FFFC);
    check("t6_addr0", bus2.imem_addr, 32'h0);
    tick(); check("t6_npc4", npc2, 32'h4);
    #2 rst2_n = 1'b0;
    #1;
    check("t6_async_req", 32'(bus2.imem_req), 32'h0);
    check("t6_async_nop", instr2, 32'h0);
    check("t6_async_valid", 32'(valid2), 32'h0);
    check("t6_async_addr", bus2.imem_addr, 32'hFFFF_FFFC);
    rst_n = 1'b0; model_reset(); wait_cnt = 0;
    #1 check("main_async_req", 32'(bus.imem_req), 32'h0);

    // randomized traffic
    do_reset(1);
    rand_lat = 1; junk_en = 1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if ($urandom_range(0, 399) == 0) begin
        do_reset(int'($urandom_range(0, 3)));
      end else begin
        stall  = ($urandom_range(0, 4) == 0);
        flush  = ($urandom_range(0, 9) == 0);
        pc_src = ($urandom_range(0, 9) == 0);
        target = $urandom & 32'hFFFF_FFFC;
      end
    end

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
